// File: rtl/uio_bus_arbiter_if.sv
// uio_bus_arbiter_if: shared uio pin bus between the requesters and the arbiter
interface uio_bus_arbiter_if #(
    parameter int NREQ = 3
);
    logic              ena;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   dir;
    logic [8*NREQ-1:0] wdata;
    logic [7:0]        uio_in;
    logic [NREQ-1:0]   gnt;
    logic [7:0]        uio_out;
    logic [7:0]        uio_oe;
    logic [7:0]        rdata;
    logic              rvalid;
    logic              busy;
    modport master (
        output ena, req, dir, wdata, uio_in,
        input  gnt, uio_out, uio_oe, rdata, rvalid, busy
    );
    modport slave (
        input  ena, req, dir, wdata, uio_in,
        output gnt, uio_out, uio_oe, rdata, rvalid, busy
    );
endinterface

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner of the shared uio pins with turnaround on direction change
module uio_bus_arbiter #(
    parameter int NREQ    = 3,
    parameter int TURN    = 1,
    parameter int MAXHOLD = 8
) (
    input logic              clk,
    input logic              rst,
    uio_bus_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {S_IDLE, S_TURN, S_OWN} state_t;
    state_t          r_state, w_state;
    logic [IW-1:0]   r_owner, w_owner, r_rr, w_rr, w_win;
    logic [IW:0]     w_idx;
    logic [7:0]      r_cnt, w_cnt, r_out, w_out, r_rdata, w_rdata, w_wsel;
    logic [NREQ-1:0] r_gnt, w_gnt;
    logic            r_oe, w_oe, r_rvalid, w_rvalid;
    logic            w_match, w_tdone, w_beat, w_last;
    // first requester at or after rr, wrapping
    always_comb begin
        w_win = r_rr;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr} + (IW+1)'(k);
            w_idx = (w_idx >= (IW+1)'(NREQ)) ? w_idx - (IW+1)'(NREQ) : w_idx;
            w_win = bus.req[w_idx[IW-1:0]] ? w_idx[IW-1:0] : w_win;
        end
    end
    assign w_wsel  = bus.wdata[{r_owner, 3'b000} +: 8];
    assign w_match = bus.dir[w_win] == r_oe;
    assign w_tdone = r_cnt == 8'(TURN - 1);
    assign w_beat  = r_gnt[r_owner] && bus.req[r_owner];
    assign w_last  = !w_beat || r_cnt == 8'(MAXHOLD - 1);
    always_comb begin
        w_state  = r_state;
        w_owner  = r_owner;
        w_rr     = r_rr;
        w_cnt    = r_cnt;
        w_gnt    = r_gnt;
        w_out    = r_out;
        w_oe     = r_oe;
        w_rdata  = r_rdata;
        w_rvalid = 1'b0;
        if (!bus.ena) begin
            w_state = S_IDLE;
            w_cnt   = '0;
            w_gnt   = '0;
            w_oe    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (|bus.req) begin
                    w_owner = w_win;
                    w_state = w_match ? S_OWN : S_TURN;
                    w_gnt   = w_match ? NREQ'(1) << w_win : '0;
                    w_oe    = w_match ? r_oe : 1'b0;
                end
                S_TURN: begin
                    w_cnt   = w_tdone ? '0 : r_cnt + 8'd1;
                    w_state = w_tdone ? S_OWN : S_TURN;
                    w_gnt   = w_tdone ? NREQ'(1) << r_owner : '0;
                    w_oe    = w_tdone ? bus.dir[r_owner] : 1'b0;
                end
                S_OWN: begin
                    w_out    = (w_beat && bus.dir[r_owner]) ? w_wsel : r_out;
                    w_rdata  = (w_beat && !bus.dir[r_owner]) ? bus.uio_in : r_rdata;
                    w_rvalid = w_beat && !bus.dir[r_owner];
                    w_cnt    = w_last ? '0 : r_cnt + 8'd1;
                    w_gnt    = w_last ? '0 : r_gnt;
                    w_state  = w_last ? S_IDLE : S_OWN;
                    w_rr     = !w_last ? r_rr : (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                end
                default: w_state = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr     <= '0;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_out    <= '0;
            r_oe     <= 1'b0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_owner  <= w_owner;
            r_rr     <= w_rr;
            r_cnt    <= w_cnt;
            r_gnt    <= w_gnt;
            r_out    <= w_out;
            r_oe     <= w_oe;
            r_rdata  <= w_rdata;
            r_rvalid <= w_rvalid;
        end
    end
    assign bus.gnt     = r_gnt;
    assign bus.uio_out = r_out;
    assign bus.uio_oe  = {8{r_oe}};
    assign bus.rdata   = r_rdata;
    assign bus.rvalid  = r_rvalid;
    assign bus.busy    = r_state != S_IDLE;
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter: vector table, corner sequences and a randomized reference-model run
module tb_uio_bus_arbiter;
    localparam int NREQ = 3, TURN = 1, MAXHOLD = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    uio_bus_arbiter_if #(.NREQ(NREQ)) bus();
    uio_bus_arbiter #(.NREQ(NREQ), .TURN(TURN), .MAXHOLD(MAXHOLD)) dut (.clk(clk), .rst(rst), .bus(bus));
    int total = 0;
    int bad = 0;
    typedef struct {
        logic rst; logic [2:0] req; logic [2:0] dir; logic [23:0] wdata; logic [7:0] uin;
        logic [2:0] gnt; logic [7:0] oe; logic [7:0] uout; logic [7:0] rd; logic rv; logic busy;
    } vec_t;
    vec_t tbl[$];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    task automatic add(input logic r, input logic [2:0] q, input logic [2:0] d, input logic [23:0] w,
                       input logic [7:0] u, input logic [2:0] g, input logic [7:0] oe, input logic [7:0] o,
                       input logic [7:0] rd, input logic rv, input logic b);
        vec_t t;
        t.rst = r; t.req = q; t.dir = d; t.wdata = w; t.uin = u;
        t.gnt = g; t.oe = oe; t.uout = o; t.rd = rd; t.rv = rv; t.busy = b;
        tbl.push_back(t);
    endtask
    task automatic drv(input logic r, input logic e, input logic [2:0] q, input logic [2:0] d,
                       input logic [23:0] w, input logic [7:0] u);
        rst = r; bus.ena = e; bus.req = q; bus.dir = d; bus.wdata = w; bus.uio_in = u;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // pin-level invariants watched on every falling edge
    bit mon_on = 1'b0;
    int zrun = 100;
    logic [7:0] poe = 8'h00;
    always @(negedge clk) if (mon_on) begin
        chk("mon_onehot", 32'($onehot0(bus.gnt)), 1);
        chk("mon_oe_val", 32'(bus.uio_oe == 8'hFF || bus.uio_oe == 8'h00), 1);
        if (bus.uio_oe == 8'hFF && poe == 8'h00) chk("mon_oe_turn", 32'(zrun >= TURN), 1);
        zrun = (bus.uio_oe == 8'h00) ? zrun + 1 : 0;
        poe = bus.uio_oe;
    end
    // reference model: owner index (-1 = none), remaining turnaround, beats this grant
    int m_own, m_tleft, m_beats, m_rr;
    bit m_granted, m_oe, m_rv;
    logic [7:0] m_out, m_rd;
    task automatic m_reset();
        m_own = -1; m_tleft = 0; m_beats = 0; m_rr = 0;
        m_granted = 0; m_oe = 0; m_rv = 0; m_out = 0; m_rd = 0;
    endtask
    task automatic m_step();
        if (rst) begin
            m_reset();
            return;
        end
        m_rv = 0;
        if (m_own < 0) begin
            for (int k = 0; k < NREQ; k++)
                if (m_own < 0 && bus.req[(m_rr + k) % NREQ]) m_own = (m_rr + k) % NREQ;
            if (m_own >= 0) begin
                if (bus.dir[m_own] == m_oe) m_granted = 1;
                else begin
                    m_tleft = TURN;
                    m_oe = 0;
                end
            end
        end else if (!m_granted) begin
            m_tleft--;
            if (m_tleft == 0) begin
                m_granted = 1;
                m_oe = bus.dir[m_own];
            end
        end else begin
            if (bus.req[m_own]) begin
                m_beats++;
                if (bus.dir[m_own]) m_out = bus.wdata[8*m_own +: 8];
                else begin
                    m_rd = bus.uio_in;
                    m_rv = 1;
                end
            end
            if (!bus.req[m_own] || m_beats == MAXHOLD) begin
                m_rr = (m_own + 1) % NREQ;
                m_own = -1;
                m_granted = 0;
                m_beats = 0;
            end
        end
    endtask
    initial begin
        logic [2:0] gs[20];
        logic [7:0] os[20];
        logic [2:0] nreq, ndir;
        int f, n;
        drv(1, 1, 0, 0, 0, 0);
        add(1, 3'b000, 3'b000, 24'h0, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0);
        add(0, 3'b001, 3'b000, 24'h0, 8'h5A, 3'b001, 8'h00, 8'h00, 8'h00, 0, 1);
        add(0, 3'b001, 3'b000, 24'h0, 8'h5A, 3'b001, 8'h00, 8'h00, 8'h5A, 1, 1);
        add(0, 3'b000, 3'b000, 24'h0, 8'h5A, 3'b000, 8'h00, 8'h00, 8'h5A, 0, 0);
        add(0, 3'b001, 3'b001, 24'h0000C3, 8'h00, 3'b000, 8'h00, 8'h00, 8'h5A, 0, 1);
        add(0, 3'b001, 3'b001, 24'h0000C3, 8'h00, 3'b001, 8'hFF, 8'h00, 8'h5A, 0, 1);
        add(0, 3'b001, 3'b001, 24'h0000C3, 8'h00, 3'b001, 8'hFF, 8'hC3, 8'h5A, 0, 1);
        add(0, 3'b000, 3'b001, 24'h0000C3, 8'h00, 3'b000, 8'hFF, 8'hC3, 8'h5A, 0, 0);
        add(1, 3'b000, 3'b111, 24'h332211, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0);
        add(0, 3'b111, 3'b111, 24'h332211, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 0, 1);
        add(0, 3'b111, 3'b111, 24'h332211, 8'h00, 3'b001, 8'hFF, 8'h00, 8'h00, 0, 1);
        add(0, 3'b111, 3'b111, 24'h332211, 8'h00, 3'b001, 8'hFF, 8'h11, 8'h00, 0, 1);
        add(0, 3'b111, 3'b111, 24'h332211, 8'h00, 3'b001, 8'hFF, 8'h11, 8'h00, 0, 1);
        add(0, 3'b110, 3'b111, 24'h332211, 8'h00, 3'b000, 8'hFF, 8'h11, 8'h00, 0, 0);
        add(0, 3'b110, 3'b111, 24'h332211, 8'h00, 3'b010, 8'hFF, 8'h11, 8'h00, 0, 1);
        add(0, 3'b110, 3'b111, 24'h332211, 8'h00, 3'b010, 8'hFF, 8'h22, 8'h00, 0, 1);
        add(0, 3'b110, 3'b111, 24'h332211, 8'h00, 3'b010, 8'hFF, 8'h22, 8'h00, 0, 1);
        add(0, 3'b100, 3'b111, 24'h332211, 8'h00, 3'b000, 8'hFF, 8'h22, 8'h00, 0, 0);
        add(0, 3'b100, 3'b111, 24'h332211, 8'h00, 3'b100, 8'hFF, 8'h22, 8'h00, 0, 1);
        add(0, 3'b100, 3'b111, 24'h332211, 8'h00, 3'b100, 8'hFF, 8'h33, 8'h00, 0, 1);
        add(0, 3'b000, 3'b111, 24'h332211, 8'h00, 3'b000, 8'hFF, 8'h33, 8'h00, 0, 0);
        foreach (tbl[i]) begin
            drv(tbl[i].rst, 1, tbl[i].req, tbl[i].dir, tbl[i].wdata, tbl[i].uin);
            step();
            mon_on = 1'b1;
            chk($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
            chk($sformatf("v%0d_oe", i), 32'(bus.uio_oe), 32'(tbl[i].oe));
            chk($sformatf("v%0d_out", i), 32'(bus.uio_out), 32'(tbl[i].uout));
            chk($sformatf("v%0d_rdata", i), 32'(bus.rdata), 32'(tbl[i].rd));
            chk($sformatf("v%0d_rvalid", i), 32'(bus.rvalid), 32'(tbl[i].rv));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
        end
        // MAXHOLD forced release with a competing requester
        drv(1, 1, 0, 0, 0, 0); step();
        drv(0, 1, 3'b011, 3'b011, 24'h00BBAA, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            gs[i] = bus.gnt;
            os[i] = bus.uio_out;
        end
        f = 0;
        while (f < 20 && gs[f] != 3'b001) f++;
        n = 0;
        while (f + n < 20 && gs[f + n] == 3'b001) n++;
        chk("hold_beats", n, MAXHOLD);
        chk("hold_gap", 32'((f + n < 20) ? gs[f + n] : 3'b111), 0);
        chk("hold_next", 32'((f + n + 1 < 20) ? gs[f + n + 1] : 3'b111), 3'b010);
        chk("hold_rewin", 32'(gs[19]), 3'b001);
        chk("hold_out", 32'(os[5]), 8'hAA);
        drv(0, 1, 0, 3'b011, 0, 0); step();
        // output owner then input owner: turnaround between them
        drv(1, 1, 0, 0, 0, 0); step();
        drv(0, 1, 3'b001, 3'b001, 24'h0000E7, 8'h3C); step(); step(); step();
        chk("ta_own0_oe", 32'(bus.uio_oe), 8'hFF);
        chk("ta_own0_out", 32'(bus.uio_out), 8'hE7);
        drv(0, 1, 3'b010, 3'b001, 24'h0000E7, 8'h3C); step();
        chk("ta_rel_oe", 32'(bus.uio_oe), 8'hFF);
        chk("ta_rel_gnt", 32'(bus.gnt), 0);
        step();
        chk("ta_turn_oe", 32'(bus.uio_oe), 8'h00);
        chk("ta_turn_gnt", 32'(bus.gnt), 0);
        chk("ta_turn_busy", 32'(bus.busy), 1);
        step();
        chk("ta_own1_gnt", 32'(bus.gnt), 3'b010);
        chk("ta_own1_oe", 32'(bus.uio_oe), 8'h00);
        step();
        chk("ta_own1_rd", 32'(bus.rdata), 8'h3C);
        chk("ta_own1_rv", 32'(bus.rvalid), 1);
        drv(0, 1, 0, 3'b001, 0, 0); step();
        // reset mid-burst
        drv(1, 1, 0, 0, 0, 0); step();
        drv(0, 1, 3'b001, 0, 0, 8'hA5); step(); step(); step();
        chk("rs_pre_rv", 32'(bus.rvalid), 1);
        drv(1, 1, 3'b001, 0, 0, 8'hA5); step();
        chk("rs_gnt", 32'(bus.gnt), 0);
        chk("rs_oe", 32'(bus.uio_oe), 8'h00);
        chk("rs_rv", 32'(bus.rvalid), 0);
        chk("rs_busy", 32'(bus.busy), 0);
        chk("rs_rdata", 32'(bus.rdata), 0);
        // ena dropped mid-burst keeps the round-robin pointer
        drv(0, 1, 3'b001, 0, 0, 8'hA5); step(); step();
        drv(0, 1, 0, 0, 0, 0); step();
        drv(0, 1, 3'b010, 3'b010, 24'h007700, 0); step(); step(); step(); step();
        chk("en_pre_oe", 32'(bus.uio_oe), 8'hFF);
        chk("en_pre_out", 32'(bus.uio_out), 8'h77);
        drv(0, 0, 3'b010, 3'b010, 24'h007700, 0); step();
        chk("en_gnt", 32'(bus.gnt), 0);
        chk("en_oe", 32'(bus.uio_oe), 8'h00);
        chk("en_rv", 32'(bus.rvalid), 0);
        chk("en_busy", 32'(bus.busy), 0);
        drv(0, 0, 3'b000, 3'b010, 0, 0); step();
        drv(0, 1, 3'b111, 3'b000, 0, 0); step();
        chk("en_rr_gnt", 32'(bus.gnt), 3'b010);
        chk("en_rr_oe", 32'(bus.uio_oe), 8'h00);
        drv(0, 1, 0, 0, 0, 0); step();
        // randomized run against the reference model
        drv(1, 1, 0, 0, 0, 0);
        m_step();
        step();
        for (int c = 0; c < 3000; c++) begin
            nreq = bus.req;
            ndir = bus.dir;
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(5) == 0) nreq[i] = ~nreq[i];
                if (!bus.req[i] && !nreq[i] && $urandom_range(3) == 0) ndir[i] = ~ndir[i];
            end
            drv(logic'($urandom_range(99) == 0), 1, nreq, ndir, 24'($urandom), 8'($urandom));
            m_step();
            step();
            chk("rnd_gnt", 32'(bus.gnt), m_granted ? 32'(1 << m_own) : 0);
            chk("rnd_oe", 32'(bus.uio_oe), m_oe ? 8'hFF : 8'h00);
            chk("rnd_out", 32'(bus.uio_out), 32'(m_out));
            chk("rnd_rdata", 32'(bus.rdata), 32'(m_rd));
            chk("rnd_rvalid", 32'(bus.rvalid), 32'(m_rv));
            chk("rnd_busy", 32'(bus.busy), 32'(m_own >= 0));
        end
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
